// File: rtl/cache_defs_pkg.sv
// Shared definitions for the data-cache victim buffer.
// Holds the buffer geometry (entry count, line-address width, line width,
// byte-offset width) and the victim-buffer controller state encoding.
package cache_defs;

    localparam int VC_ENTRIES  = 4;
    localparam int LINE_ADDR_W = 28;
    localparam int LINE_W      = 128;
    localparam int OFFSET_W    = 4;

    typedef enum logic [1:0] {
        VC_IDLE,
        VC_DRAIN,
        VC_FLUSH,
        VC_FLUSH_DONE
    } type_vc_states_e;

endpackage

// File: rtl/vc_entry_match.sv
// Parallel line-address compare across all victim-buffer entries.
// Ports:
//   valid      - per-entry valid bits; invalid entries never match
//   entry_addr - stored line address of every entry
//   addr       - line address being searched for
//   hit_vec    - one-hot vector of matching entries (all zero on a miss)
//   hit_idx    - encoded index of the matching entry (0 on a miss)
module vc_entry_match
    import cache_defs::*;
#(
    parameter int ENTRIES = VC_ENTRIES,
    parameter int ADDR_W  = LINE_ADDR_W
) (
    input  logic [ENTRIES-1:0]             valid,
    input  logic [ENTRIES-1:0][ADDR_W-1:0] entry_addr,
    input  logic [ADDR_W-1:0]              addr,
    output logic [ENTRIES-1:0]             hit_vec,
    output logic [$clog2(ENTRIES)-1:0]     hit_idx
);

    localparam int IDX_W = $clog2(ENTRIES);

    // The buffer never holds duplicate addresses, so at most one bit of
    // hit_vec is set and the encoder needs no priority.
    always_comb begin
        hit_vec = '0;
        hit_idx = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            hit_vec[i] = valid[i] && (entry_addr[i] == addr);
            if (hit_vec[i]) begin
                hit_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/dcache_victim_buffer.sv
// Fully-associative victim buffer beside the write-back data cache.
// Ports:
//   clk, rst_n            - clock, synchronous active-low reset
//   lookup_req_i/addr_i   - latch a byte address for a victim lookup
//   victim_hit_o          - latched address hits a valid entry
//   hit_line_o/hit_word_o - hit line data and the word picked by the offset
//   ins_i/addr/line/dirty - insert a line evicted from the dcache
//   extract_i             - hand the hit entry back to the dcache, freeing it
//   flush_i               - write back every dirty entry, then invalidate all
//   flush_done_o          - one-cycle pulse when a flush finishes
//   kill_i                - cancel the latched lookup
//   busy_o                - drain or flush in progress; inserts are dropped
//   vc2mem_req/addr/data  - write-back request to data memory
//   mem2vc_ack_i          - memory accepted the write-back
module dcache_victim_buffer
    import cache_defs::*;
(
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            lookup_req_i,
    input  logic [LINE_ADDR_W+OFFSET_W-1:0] lookup_addr_i,
    output logic                            victim_hit_o,
    output logic [LINE_W-1:0]               hit_line_o,
    output logic [31:0]                     hit_word_o,
    input  logic                            ins_i,
    input  logic [LINE_ADDR_W-1:0]          ins_addr_i,
    input  logic [LINE_W-1:0]               ins_line_i,
    input  logic                            ins_dirty_i,
    input  logic                            extract_i,
    input  logic                            flush_i,
    output logic                            flush_done_o,
    input  logic                            kill_i,
    output logic                            busy_o,
    output logic                            vc2mem_req_o,
    output logic [LINE_ADDR_W-1:0]          vc2mem_addr_o,
    output logic [LINE_W-1:0]               vc2mem_data_o,
    input  logic                            mem2vc_ack_i
);

    localparam int IDX_W  = $clog2(VC_ENTRIES);
    localparam int WSEL_W = OFFSET_W - 2;
    localparam int WORDS  = LINE_W / 32;

    type_vc_states_e state;

    logic [VC_ENTRIES-1:0]                  valid;
    logic [VC_ENTRIES-1:0]                  dirty;
    logic [VC_ENTRIES-1:0][LINE_ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0]                      line_q [VC_ENTRIES];
    logic [IDX_W-1:0]                       rr_ptr;
    logic [IDX_W-1:0]                       flush_idx;
    logic                                   flush_pend;
    logic [LINE_ADDR_W-1:0]                 drain_addr;
    logic [LINE_W-1:0]                      drain_data;

    logic                                   lk_valid;
    logic [LINE_ADDR_W+OFFSET_W-1:0]        lk_addr;
    logic [WSEL_W-1:0]                      lk_wsel;
    logic                                   unused_byte_bits;

    logic [VC_ENTRIES-1:0]                  lk_hit_vec;
    logic [IDX_W-1:0]                       lk_idx;
    logic                                   ext_fire;
    logic [VC_ENTRIES-1:0]                  valid_eff;

    logic [VC_ENTRIES-1:0]                  ins_hit_vec;
    logic [IDX_W-1:0]                       ins_idx;
    logic                                   ins_hit;
    logic                                   free_found;
    logic [IDX_W-1:0]                       free_idx;
    logic [IDX_W-1:0]                       ins_slot;
    logic                                   ins_evict;

    assign lk_wsel          = lk_addr[OFFSET_W-1:2];
    assign unused_byte_bits = ^lk_addr[1:0];

    vc_entry_match u_lookup_match (
        .valid      (valid),
        .entry_addr (addr_q),
        .addr       (lk_addr[LINE_ADDR_W+OFFSET_W-1:OFFSET_W]),
        .hit_vec    (lk_hit_vec),
        .hit_idx    (lk_idx)
    );

    assign victim_hit_o = lk_valid && (|lk_hit_vec);
    assign ext_fire     = extract_i && victim_hit_o;

    // An extract frees its entry before the insert is placed, so a swap
    // can land in the slot the extract just vacated.
    assign valid_eff = valid & ~(ext_fire ? lk_hit_vec : '0);

    vc_entry_match u_ins_match (
        .valid      (valid_eff),
        .entry_addr (addr_q),
        .addr       (ins_addr_i),
        .hit_vec    (ins_hit_vec),
        .hit_idx    (ins_idx)
    );

    assign ins_hit = |ins_hit_vec;

    // Lowest-index free slot: scanning downward lets the lowest index win.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = VC_ENTRIES - 1; i >= 0; i--) begin
            if (!valid_eff[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    assign ins_evict = !ins_hit && !free_found;
    assign ins_slot  = ins_hit ? ins_idx : (free_found ? free_idx : rr_ptr);

    // Hit data is zeroed on a miss so the outputs stay quiet when idle.
    assign hit_line_o = victim_hit_o ? line_q[lk_idx] : '0;

    always_comb begin
        hit_word_o = '0;
        for (int w = 0; w < WORDS; w++) begin
            if (lk_wsel == WSEL_W'(w)) begin
                hit_word_o = hit_line_o[w*32 +: 32];
            end
        end
    end

    assign busy_o        = (state != VC_IDLE);
    assign vc2mem_req_o  = (state == VC_DRAIN);
    assign vc2mem_addr_o = vc2mem_req_o ? drain_addr : '0;
    assign vc2mem_data_o = vc2mem_req_o ? drain_data : '0;
    assign flush_done_o  = (state == VC_FLUSH_DONE);

    // Lookup latch; kill wins over a new request in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lk_valid <= 1'b0;
            lk_addr  <= '0;
        end else if (kill_i) begin
            lk_valid <= 1'b0;
        end else if (lookup_req_i) begin
            lk_valid <= 1'b1;
            lk_addr  <= lookup_addr_i;
        end
    end

    // Entry storage and controller FSM. The extract clear is written first
    // so a same-cycle insert into the freed slot overrides it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= VC_IDLE;
            valid      <= '0;
            dirty      <= '0;
            rr_ptr     <= '0;
            flush_idx  <= '0;
            flush_pend <= 1'b0;
            drain_addr <= '0;
            drain_data <= '0;
        end else begin
            if (ext_fire) begin
                valid[lk_idx] <= 1'b0;
                dirty[lk_idx] <= 1'b0;
            end
            case (state)
                VC_IDLE: begin
                    if (flush_i) begin
                        state     <= VC_FLUSH;
                        flush_idx <= '0;
                    end else if (ins_i) begin
                        valid[ins_slot]  <= 1'b1;
                        addr_q[ins_slot] <= ins_addr_i;
                        line_q[ins_slot] <= ins_line_i;
                        dirty[ins_slot]  <= ins_dirty_i | (ins_hit & dirty[ins_slot]);
                        if (ins_evict) begin
                            rr_ptr <= rr_ptr + 1'b1;
                            if (dirty[rr_ptr]) begin
                                drain_addr <= addr_q[rr_ptr];
                                drain_data <= line_q[rr_ptr];
                                state      <= VC_DRAIN;
                            end
                        end
                    end
                end
                VC_DRAIN: begin
                    if (mem2vc_ack_i) begin
                        state <= flush_pend ? VC_FLUSH : VC_IDLE;
                    end
                end
                VC_FLUSH: begin
                    // A dirty entry stays valid (now clean) while it drains;
                    // the revisit after the ack invalidates it.
                    if (valid_eff[flush_idx] && dirty[flush_idx]) begin
                        drain_addr       <= addr_q[flush_idx];
                        drain_data       <= line_q[flush_idx];
                        dirty[flush_idx] <= 1'b0;
                        flush_pend       <= 1'b1;
                        state            <= VC_DRAIN;
                    end else begin
                        valid[flush_idx] <= 1'b0;
                        flush_idx        <= flush_idx + 1'b1;
                        if (flush_idx == IDX_W'(VC_ENTRIES - 1)) begin
                            state <= VC_FLUSH_DONE;
                        end
                    end
                end
                VC_FLUSH_DONE: begin
                    flush_pend <= 1'b0;
                    flush_idx  <= '0;
                    state      <= VC_IDLE;
                end
                default: state <= VC_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_victim_buffer.sv
// Scoreboard bench for dcache_victim_buffer: directed stimulus pushes the
// expected lookup results, write-backs and flush completions into queues;
// a monitor on the falling edge pops and compares whenever the DUT presents
// a lookup result, a write-back request or a flush-done pulse.
module tb_dcache_victim_buffer;
    import cache_defs::*;

    localparam int AW = LINE_ADDR_W + OFFSET_W;

    logic                   clk;
    logic                   rst_n;
    logic                   lookup_req_i;
    logic [AW-1:0]          lookup_addr_i;
    logic                   victim_hit_o;
    logic [LINE_W-1:0]      hit_line_o;
    logic [31:0]            hit_word_o;
    logic                   ins_i;
    logic [LINE_ADDR_W-1:0] ins_addr_i;
    logic [LINE_W-1:0]      ins_line_i;
    logic                   ins_dirty_i;
    logic                   extract_i;
    logic                   flush_i;
    logic                   flush_done_o;
    logic                   kill_i;
    logic                   busy_o;
    logic                   vc2mem_req_o;
    logic [LINE_ADDR_W-1:0] vc2mem_addr_o;
    logic [LINE_W-1:0]      vc2mem_data_o;
    logic                   mem2vc_ack_i;

    dcache_victim_buffer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .lookup_req_i  (lookup_req_i),
        .lookup_addr_i (lookup_addr_i),
        .victim_hit_o  (victim_hit_o),
        .hit_line_o    (hit_line_o),
        .hit_word_o    (hit_word_o),
        .ins_i         (ins_i),
        .ins_addr_i    (ins_addr_i),
        .ins_line_i    (ins_line_i),
        .ins_dirty_i   (ins_dirty_i),
        .extract_i     (extract_i),
        .flush_i       (flush_i),
        .flush_done_o  (flush_done_o),
        .kill_i        (kill_i),
        .busy_o        (busy_o),
        .vc2mem_req_o  (vc2mem_req_o),
        .vc2mem_addr_o (vc2mem_addr_o),
        .vc2mem_data_o (vc2mem_data_o),
        .mem2vc_ack_i  (mem2vc_ack_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic              hit;
        logic [31:0]       word;
        logic [LINE_W-1:0] line;
    } lk_exp_t;

    typedef struct {
        logic [LINE_ADDR_W-1:0] addr;
        logic [LINE_W-1:0]      data;
    } wb_exp_t;

    typedef struct {
        bit                     lookup;
        logic [AW-1:0]          laddr;
        bit                     ins;
        logic [LINE_ADDR_W-1:0] iaddr;
        logic [7:0]             ib;
        bit                     idirty;
        bit                     extract;
        bit                     flush;
        bit                     kill;
    } stim_t;

    lk_exp_t lk_q[$];
    wb_exp_t wb_q[$];
    bit      fd_q[$];

    int errors = 0;
    int checks = 0;

    // Line filled with byte b in the upper three bytes and the word index
    // in the low byte, so every word of every line is distinct.
    function automatic logic [LINE_W-1:0] mk_line(input logic [7:0] b);
        logic [LINE_W-1:0] r;
        r = '0;
        for (int w = 0; w < LINE_W / 32; w++) begin
            r[w*32 +: 32] = {b, b, b, 8'(w)};
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [LINE_W-1:0] actual,
                               input logic [LINE_W-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic reportUnexpected(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: DUT presented an output with no expectation queued", name);
    endtask

    // One clock of stimulus; inputs return to idle right after the edge.
    task automatic applyStimulus(input stim_t s);
        lookup_req_i  = s.lookup;
        lookup_addr_i = s.laddr;
        ins_i         = s.ins;
        ins_addr_i    = s.iaddr;
        ins_line_i    = mk_line(s.ib);
        ins_dirty_i   = s.idirty;
        extract_i     = s.extract;
        flush_i       = s.flush;
        kill_i        = s.kill;
        @(posedge clk);
        #1;
        lookup_req_i  = 1'b0;
        lookup_addr_i = '0;
        ins_i         = 1'b0;
        ins_addr_i    = '0;
        ins_line_i    = '0;
        ins_dirty_i   = 1'b0;
        extract_i     = 1'b0;
        flush_i       = 1'b0;
        kill_i        = 1'b0;
    endtask

    task automatic pushLookup(input bit exp_hit, input logic [7:0] b, input int off);
        lk_exp_t e;
        e.hit  = exp_hit;
        e.word = exp_hit ? {b, b, b, 8'(off / 4)} : 32'h0;
        e.line = exp_hit ? mk_line(b) : '0;
        lk_q.push_back(e);
    endtask

    task automatic doLookup(input logic [LINE_ADDR_W-1:0] la, input int off,
                            input bit exp_hit, input logic [7:0] b, input bit ext);
        stim_t s;
        s = '{default: 0};
        s.lookup  = 1'b1;
        s.laddr   = {la, OFFSET_W'(off)};
        s.extract = ext;
        pushLookup(exp_hit, b, off);
        applyStimulus(s);
    endtask

    task automatic doInsert(input logic [LINE_ADDR_W-1:0] la, input logic [7:0] b,
                            input bit d);
        stim_t s;
        s = '{default: 0};
        s.ins    = 1'b1;
        s.iaddr  = la;
        s.ib     = b;
        s.idirty = d;
        applyStimulus(s);
    endtask

    task automatic pushWb(input logic [LINE_ADDR_W-1:0] la, input logic [7:0] b);
        wb_exp_t e;
        e.addr = la;
        e.data = mk_line(b);
        wb_q.push_back(e);
    endtask

    task automatic waitIdle(input int budget, input string name);
        int n;
        n = 0;
        while (busy_o && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (busy_o) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: busy_o still 1 after %0d cycles, expected 0", name, budget);
        end
    endtask

    task automatic waitReq(input int budget, input string name);
        int n;
        n = 0;
        while (!vc2mem_req_o && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!vc2mem_req_o) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: vc2mem_req_o still 0 after %0d cycles, expected 1", name, budget);
        end
    endtask

    // Memory model: acknowledge each write-back on its third request cycle.
    initial begin
        int cnt;
        cnt = 0;
        mem2vc_ack_i = 1'b0;
        forever begin
            @(negedge clk);
            if (vc2mem_req_o && !mem2vc_ack_i) begin
                cnt++;
                if (cnt == 3) begin
                    mem2vc_ack_i = 1'b1;
                    cnt = 0;
                end
            end else begin
                mem2vc_ack_i = 1'b0;
                cnt = 0;
            end
        end
    end

    // Monitor: a lookup issued at an edge presents its result before the next.
    logic lk_issued = 1'b0;
    always @(posedge clk) lk_issued <= rst_n && lookup_req_i && !kill_i;

    bit      wb_active = 1'b0;
    wb_exp_t wb_cur;

    always @(negedge clk) begin
        if (lk_issued) begin
            if (lk_q.size() == 0) begin
                reportUnexpected("lookup");
            end else begin
                lk_exp_t e;
                e = lk_q.pop_front();
                checkOutput("lookup_hit", victim_hit_o, e.hit);
                checkOutput("lookup_word", hit_word_o, e.word);
                checkOutput("lookup_line", hit_line_o, e.line);
            end
        end
        if (vc2mem_req_o) begin
            if (!wb_active) begin
                wb_active = 1'b1;
                if (wb_q.size() == 0) begin
                    reportUnexpected("writeback");
                    wb_cur.addr = vc2mem_addr_o;
                    wb_cur.data = vc2mem_data_o;
                end else begin
                    wb_cur = wb_q.pop_front();
                end
            end
            checkOutput("wb_addr", vc2mem_addr_o, wb_cur.addr);
            checkOutput("wb_data", vc2mem_data_o, wb_cur.data);
            checkOutput("wb_busy", busy_o, 1'b1);
        end else begin
            wb_active = 1'b0;
        end
        if (flush_done_o) begin
            if (fd_q.size() == 0) begin
                reportUnexpected("flush_done");
            end else begin
                void'(fd_q.pop_front());
                checkOutput("flush_done_busy", busy_o, 1'b1);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    localparam logic [LINE_ADDR_W-1:0] LA = 28'h0100000;
    localparam logic [LINE_ADDR_W-1:0] L0 = 28'h0000100;
    localparam logic [LINE_ADDR_W-1:0] L1 = 28'h0000200;
    localparam logic [LINE_ADDR_W-1:0] L2 = 28'h0000300;
    localparam logic [LINE_ADDR_W-1:0] L3 = 28'h0000400;
    localparam logic [LINE_ADDR_W-1:0] L4 = 28'h0000500;
    localparam logic [LINE_ADDR_W-1:0] L5 = 28'h0000600;
    localparam logic [LINE_ADDR_W-1:0] L6 = 28'h0000700;
    localparam logic [LINE_ADDR_W-1:0] LB = 28'h0000800;
    localparam logic [LINE_ADDR_W-1:0] LC = 28'h0000900;

    initial begin
        stim_t s;
        rst_n         = 1'b0;
        lookup_req_i  = 1'b0;
        lookup_addr_i = '0;
        ins_i         = 1'b0;
        ins_addr_i    = '0;
        ins_line_i    = '0;
        ins_dirty_i   = 1'b0;
        extract_i     = 1'b0;
        flush_i       = 1'b0;
        kill_i        = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_hit", victim_hit_o, 1'b0);
        checkOutput("reset_line", hit_line_o, '0);
        checkOutput("reset_busy", busy_o, 1'b0);
        checkOutput("reset_req", vc2mem_req_o, 1'b0);
        checkOutput("reset_wb_addr", vc2mem_addr_o, '0);
        checkOutput("reset_flush_done", flush_done_o, 1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] empty-buffer lookup");
        doLookup(28'h1000004, 0, 1'b0, 8'h00, 1'b0);
        checkOutput("empty_busy", busy_o, 1'b0);

        $display("[TB] insert, hit word, extract");
        doInsert(LA, 8'hAA, 1'b0);
        doLookup(LA, 8, 1'b1, 8'hAA, 1'b0);
        doLookup(LA, 8, 1'b0, 8'h00, 1'b1);

        $display("[TB] fill, dirty round-robin eviction, insert while busy");
        doInsert(L0, 8'h10, 1'b1);
        doInsert(L1, 8'h11, 1'b0);
        doInsert(L2, 8'h12, 1'b0);
        doInsert(L3, 8'h13, 1'b0);
        pushWb(L0, 8'h10);
        doInsert(L4, 8'h14, 1'b0);
        checkOutput("drain_busy", busy_o, 1'b1);
        doInsert(L5, 8'h15, 1'b0);
        waitIdle(20, "drain_l0");
        doLookup(L5, 0, 1'b0, 8'h00, 1'b0);
        doLookup(L4, 4, 1'b1, 8'h14, 1'b0);
        doLookup(L0, 0, 1'b0, 8'h00, 1'b0);
        doLookup(L1, 12, 1'b1, 8'h11, 1'b0);

        $display("[TB] clean eviction at rr_ptr=1");
        doInsert(L6, 8'h16, 1'b0);
        checkOutput("clean_evict_busy", busy_o, 1'b0);
        doLookup(L1, 0, 1'b0, 8'h00, 1'b0);
        doLookup(L6, 0, 1'b1, 8'h16, 1'b0);

        $display("[TB] same-cycle extract and insert");
        doLookup(L2, 0, 1'b1, 8'h12, 1'b0);
        s = '{default: 0};
        s.lookup  = 1'b1;
        s.laddr   = {L2, OFFSET_W'(0)};
        s.extract = 1'b1;
        s.ins     = 1'b1;
        s.iaddr   = LB;
        s.ib      = 8'hBB;
        s.idirty  = 1'b1;
        pushLookup(1'b0, 8'h00, 0);
        applyStimulus(s);
        checkOutput("swap_busy", busy_o, 1'b0);
        doLookup(LB, 8, 1'b1, 8'hBB, 1'b0);
        // rr_ptr should still be 2, so the next eviction displaces dirty B.
        pushWb(LB, 8'hBB);
        doInsert(LC, 8'hCC, 1'b0);
        waitIdle(20, "drain_b");
        doLookup(LB, 0, 1'b0, 8'h00, 1'b0);
        doLookup(LC, 4, 1'b1, 8'hCC, 1'b0);

        $display("[TB] flush with entries 1 and 3 dirty");
        doInsert(L6, 8'h26, 1'b1);
        doInsert(L3, 8'h23, 1'b1);
        doInsert(L6, 8'h36, 1'b0);
        checkOutput("rewrite_busy", busy_o, 1'b0);
        doLookup(L6, 4, 1'b1, 8'h36, 1'b0);
        pushWb(L6, 8'h36);
        pushWb(L3, 8'h23);
        fd_q.push_back(1'b1);
        s = '{default: 0};
        s.flush = 1'b1;
        applyStimulus(s);
        checkOutput("flush_busy", busy_o, 1'b1);
        waitReq(20, "flush_first_req");
        s = '{default: 0};
        s.kill = 1'b1;
        applyStimulus(s);
        checkOutput("kill_keeps_req", vc2mem_req_o, 1'b1);
        waitIdle(60, "flush");
        checkOutput("post_flush_done", flush_done_o, 1'b0);
        checkOutput("post_flush_hit", victim_hit_o, 1'b0);
        doLookup(L4, 0, 1'b0, 8'h00, 1'b0);
        doLookup(L6, 0, 1'b0, 8'h00, 1'b0);
        doLookup(LC, 0, 1'b0, 8'h00, 1'b0);
        doLookup(L3, 0, 1'b0, 8'h00, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("lookups_outstanding", 32'(lk_q.size()), 32'd0);
        checkOutput("writebacks_outstanding", 32'(wb_q.size()), 32'd0);
        checkOutput("flush_done_outstanding", 32'(fd_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
